// File: rtl/rr_lock_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter_if
// Description : Request/release/grant bundle between requesters and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_lock_arbiter_if;
    logic [2:0] req;
    logic [2:0] rel;
    logic [2:0] gnt;
    logic       busy;
    logic       timeout_err;
    logic       state_err;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  busy,
        input  timeout_err,
        input  state_err
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output busy,
        output timeout_err,
        output state_err
    );
endinterface
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter
// Description : Three-way round-robin lock arbiter with hold limit and
//               release gap; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_lock_arbiter_if.slave   bus
);

    localparam logic [1:0] c_IDLE      = 2'b00;
    localparam logic [1:0] c_GRANT     = 2'b01;
    localparam logic [1:0] c_RELEASE   = 2'b10;
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [2:0] r_gnt;
    logic       r_busy;
    logic       r_timeout_err;
    logic       r_state_err;
    logic [7:0] r_hold_cnt;
    logic [1:0] r_owner;
    logic [1:0] r_last;

    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic [1:0] w_winner;
    logic       w_release;

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    f_onehot = 3'b001;
            2'd1:    f_onehot = 3'b010;
            2'd2:    f_onehot = 3'b100;
            default: f_onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] f_next(input logic [1:0] idx);
        f_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search order last+1, last+2, last; r_gnt is the owner's one-hot mask in GRANT.
    always_comb begin
        w_cand1 = f_next(r_last);
        w_cand2 = f_next(w_cand1);
        if (|(bus.req & f_onehot(w_cand1))) begin
            w_winner = w_cand1;
        end else if (|(bus.req & f_onehot(w_cand2))) begin
            w_winner = w_cand2;
        end else begin
            w_winner = r_last;
        end
        w_release = (|(bus.rel & r_gnt)) || !(|(bus.req & r_gnt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_gnt         <= 3'b000;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_state_err   <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_owner       <= 2'd0;
            r_last        <= 2'd2;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (|bus.req) begin
                        r_owner    <= w_winner;
                        r_gnt      <= f_onehot(w_winner);
                        r_hold_cnt <= 8'd0;
                        r_busy     <= 1'b1;
                        r_state    <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    // A release coinciding with the hold limit is a normal release.
                    if (w_release) begin
                        r_gnt   <= 3'b000;
                        r_state <= c_RELEASE;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        r_gnt         <= 3'b000;
                        r_timeout_err <= 1'b1;
                        r_state       <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    r_last  <= r_owner;
                    r_gnt   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_gnt       <= 3'b000;
                    r_busy      <= 1'b0;
                    r_state_err <= 1'b1;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.state_err   = r_state_err;

endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_lock_arbiter
// Description : Directed self-checking bench for rr_lock_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rr_lock_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rr_lock_arbiter_if bus ();

    rr_lock_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 3'b000;
        bus.rel = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 3'b000;
        bus.rel = 3'b000;
        #3;
        checks++;
        if (bus.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", bus.gnt); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout_err); end
        checks++;
        if (bus.state_err !== 1'b0) begin errors++; $display("FAIL reset_state_err got=%b exp=0", bus.state_err); end
        @(negedge clk);
        rst_n = 1'b1;
        // Idle with no request: nothing may be granted.
        repeat (2) @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b000) begin errors++; $display("FAIL idle_hold_gnt got=%b exp=000", bus.gnt); end
    endtask

    // All three requesting: 8-cycle grants with timeout, rotating 0,1,2,0.
    task automatic test_rotation();
        logic [2:0] exp_gnt;
        do_reset();
        bus.req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                exp_gnt = (c < 8) ? (3'b001 << (g % 3)) : 3'b000;
                checks++;
                if (bus.gnt !== exp_gnt) begin
                    errors++;
                    $display("FAIL rotation_gnt g=%0d c=%0d got=%b exp=%b", g, c, bus.gnt, exp_gnt);
                end
                checks++;
                if (bus.timeout_err !== (c == 8)) begin
                    errors++;
                    $display("FAIL rotation_timeout g=%0d c=%0d got=%b exp=%b", g, c, bus.timeout_err, (c == 8));
                end
                checks++;
                if (bus.busy !== (c < 9)) begin
                    errors++;
                    $display("FAIL rotation_busy g=%0d c=%0d got=%b exp=%b", g, c, bus.busy, (c < 9));
                end
            end
        end
        bus.req = 3'b000;
    endtask

    task automatic test_early_release();
        logic [2:0] exp_gnt;
        do_reset();
        bus.req = 3'b010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_gnt = (c < 3 || c == 5) ? 3'b010 : 3'b000;
            checks++;
            if (bus.gnt !== exp_gnt) begin
                errors++;
                $display("FAIL early_rel_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_gnt);
            end
            checks++;
            if (bus.timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL early_rel_timeout c=%0d got=%b exp=0", c, bus.timeout_err);
            end
            bus.rel = (c == 2) ? 3'b010 : 3'b000;
        end
        bus.req = 3'b000;
        bus.rel = 3'b000;
    endtask

    task automatic test_timeout();
        logic [2:0] exp_gnt;
        do_reset();
        bus.req = 3'b001;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            exp_gnt = (c < 8 || c == 10) ? 3'b001 : 3'b000;
            checks++;
            if (bus.gnt !== exp_gnt) begin
                errors++;
                $display("FAIL timeout_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_gnt);
            end
            checks++;
            if (bus.timeout_err !== (c == 8)) begin
                errors++;
                $display("FAIL timeout_pulse c=%0d got=%b exp=%b", c, bus.timeout_err, (c == 8));
            end
        end
        bus.req = 3'b000;
    endtask

    // Release strobe in the final allowed cycle counts as a release, not a timeout.
    task automatic test_release_at_limit();
        do_reset();
        bus.req = 3'b001;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin errors++; $display("FAIL limit_rel_pre got=%b exp=001", bus.gnt); end
        bus.rel = 3'b001;
        @(negedge clk);
        bus.rel = 3'b000;
        bus.req = 3'b000;
        checks++;
        if (bus.gnt !== 3'b000) begin errors++; $display("FAIL limit_rel_gnt got=%b exp=000", bus.gnt); end
        checks++;
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL limit_rel_timeout got=%b exp=0", bus.timeout_err); end
        @(negedge clk);
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.req = 3'b010;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin errors++; $display("FAIL drop_first got=%b exp=010", bus.gnt); end
        bus.rel = 3'b101;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin errors++; $display("FAIL drop_nonowner_rel got=%b exp=010", bus.gnt); end
        bus.rel = 3'b000;
        bus.req = 3'b101;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b000) begin errors++; $display("FAIL drop_release got=%b exp=000", bus.gnt); end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b000) begin errors++; $display("FAIL drop_gap got=%b exp=000", bus.gnt); end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b100) begin errors++; $display("FAIL drop_next got=%b exp=100", bus.gnt); end
        bus.req = 3'b000;
    endtask

    task automatic test_illegal_state();
        do_reset();
        bus.req = 3'b001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin errors++; $display("FAIL illegal_pre got=%b exp=001", bus.gnt); end
        bus.req = 3'b000;
        force dut.r_state = 2'b11;
        @(negedge clk);
        release dut.r_state;
        checks++;
        if (bus.gnt !== 3'b000) begin errors++; $display("FAIL illegal_gnt got=%b exp=000", bus.gnt); end
        checks++;
        if (bus.state_err !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b exp=1", bus.state_err); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        checks++;
        if (dut.r_state !== 2'b00) begin errors++; $display("FAIL illegal_recover got=%b exp=00", dut.r_state); end
        bus.req = 3'b001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin errors++; $display("FAIL illegal_regrant got=%b exp=001", bus.gnt); end
        checks++;
        if (bus.state_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b exp=1", bus.state_err); end
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 3'b100;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b100) begin errors++; $display("FAIL async_pre got=%b exp=100", bus.gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 3'b000) begin errors++; $display("FAIL async_gnt got=%b exp=000", bus.gnt); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", bus.busy); end
        bus.req = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin errors++; $display("FAIL async_first got=%b exp=001", bus.gnt); end
        bus.req = 3'b000;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        bus.req = 3'b000;
        bus.rel = 3'b000;
        test_reset();
        test_rotation();
        test_early_release();
        test_timeout();
        test_release_at_limit();
        test_owner_drop();
        test_illegal_state();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
